// File: rtl/adau_spi_arbiter_if.sv
// Handshake bundle between the command sources, the arbiter and the SPI master.
// slave = arbiter view, master = SoC/source view.
interface adau_spi_arbiter_if #(
    parameter int CMD_W      = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [CMD_W-1:0] init_cmd;
    logic             init_valid;
    logic             init_ready;
    logic             init_done;
    logic [CMD_W-1:0] rt_cmd;
    logic             rt_valid;
    logic             rt_ready;
    logic [CMD_W-1:0] spi_cmd;
    logic             spi_valid;
    logic             spi_ready;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;

    modport slave (
        input  init_cmd, init_valid, init_done, rt_cmd, rt_valid, spi_ready,
        output init_ready, rt_ready, spi_cmd, spi_valid, busy, fifo_level
    );

    modport master (
        output init_cmd, init_valid, init_done, rt_cmd, rt_valid, spi_ready,
        input  init_ready, rt_ready, spi_cmd, spi_valid, busy, fifo_level
    );
endinterface

// File: rtl/adau_spi_arbiter.sv
// Arbitrates boot-time init commands and buffered runtime writes onto one SPI master,
// with a guard gap after each command. ADAU_SPI_ARB_STATS_EN adds cmd_count/rt_stall.
module adau_spi_arbiter #(
    parameter int CMD_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    adau_spi_arbiter_if.slave   bus
`ifdef ADAU_SPI_ARB_STATS_EN
    ,
    output logic [15:0]         cmd_count,
    output logic                rt_stall
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t           state_q, state_d;
    logic [CMD_W-1:0] spi_cmd_q;
    logic [CMD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [CNT_W-1:0] gap_q;

    logic grant_init, grant_rt, push, pop, fifo_full;

    // init wins outright; rt is only considered once init has finished
    assign grant_init = (state_q == IDLE) && !bus.init_done && bus.init_valid;
    assign grant_rt   = (state_q == IDLE) && bus.init_done && (level_q != '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign push       = bus.rt_valid && !fifo_full;
    assign pop        = grant_rt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_init || grant_rt) state_d = ISSUE;
            ISSUE:   if (bus.spi_ready)          state_d = GAP;
            GAP:     if (gap_q == '0)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            spi_cmd_q <= '0;
            gap_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant_init)
                spi_cmd_q <= bus.init_cmd;
            else if (grant_rt)
                spi_cmd_q <= mem[rd_ptr_q];
            if (state_q == ISSUE && bus.spi_ready)
                gap_q <= CNT_W'(GAP_CYCLES - 1);
            else if (state_q == GAP && gap_q != '0)
                gap_q <= gap_q - 1'b1;
        end
    end

    // storage needs no reset; validity is tracked by level_q
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.rt_cmd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign bus.init_ready = grant_init;
    assign bus.rt_ready   = !fifo_full;
    assign bus.spi_cmd    = spi_cmd_q;
    assign bus.spi_valid  = (state_q == ISSUE);
    assign bus.busy       = (state_q != IDLE) || (level_q != '0);
    assign bus.fifo_level = level_q;

`ifdef ADAU_SPI_ARB_STATS_EN
    logic [15:0] cmd_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cmd_cnt_q <= '0;
        else if (bus.spi_valid && bus.spi_ready)
            cmd_cnt_q <= cmd_cnt_q + 16'd1;
    end

    assign cmd_count = cmd_cnt_q;
    assign rt_stall  = bus.rt_valid && fifo_full;
`endif
endmodule
